// File: rtl/mux8_scan_ctrl.sv
// Sequencer for an 8:1 mux stage: holds an accepted word on the mux data
// inputs, walks the select once per accepted beat, and streams the mux output back.
module mux8_scan_ctrl #(
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [7:0]       mux_e,
  output logic [2:0]       mux_s,
  input  logic             mux_y,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam logic [2:0] SEL_START = (MSB_FIRST != 0) ? 3'd7 : 3'd0;

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_mux_e;
  logic [2:0]       r_mux_s;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_word_cnt;
  logic             w_load;
  logic             w_beat;
  logic             w_last_beat;

  // A word may load while idle, or in the same cycle its predecessor's last bit leaves.
  always_comb begin
    w_next_state = r_state;
    out_valid    = 1'b0;
    busy         = 1'b0;
    out_last     = 1'b0;
    in_ready     = 1'b0;
    w_load       = 1'b0;
    w_beat       = 1'b0;
    w_last_beat  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        w_load   = in_valid;
        if (w_load) w_next_state = SCAN;
      end
      SCAN: begin
        out_valid   = 1'b1;
        busy        = 1'b1;
        out_last    = (r_idx == 3'd7);
        in_ready    = out_last && out_ready;
        w_beat      = out_ready;
        w_last_beat = w_beat && out_last;
        w_load      = in_valid && in_ready;
        if (w_last_beat && !w_load) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_e    <= 8'd0;
      r_mux_s    <= SEL_START;
      r_idx      <= 3'd0;
      r_word_cnt <= '0;
    end else begin
      if (w_load) begin
        r_mux_e <= in_data;
        r_mux_s <= SEL_START;
        r_idx   <= 3'd0;
      end else if (w_beat) begin
        r_mux_s <= (MSB_FIRST != 0) ? r_mux_s - 3'd1 : r_mux_s + 3'd1;
        r_idx   <= r_idx + 3'd1;
      end
      if (w_last_beat) r_word_cnt <= r_word_cnt + CNT_W'(1);
    end
  end

  assign mux_e    = r_mux_e;
  assign mux_s    = r_mux_s;
  assign out_bit  = mux_y;
  assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed bench for mux8_scan_ctrl: instance A is LSB-first with an 8-bit counter,
// instance B is MSB-first with a 2-bit counter; each drives a behavioural 8:1 mux.
module tb_mux8_scan_ctrl;

  logic       clk;
  logic       rstN[2];
  logic       inValid[2];
  logic [7:0] inData[2];
  logic       inReady[2];
  logic [7:0] muxE[2];
  logic [2:0] muxS[2];
  logic       muxYA;
  logic       muxYB;
  logic       outValid[2];
  logic       outBit[2];
  logic       outLast[2];
  logic       outReady[2];
  logic       busy[2];
  logic [7:0] wordCntA;
  logic [1:0] wordCntB;

  int testsRun  = 0;
  int failCount = 0;

  mux8_scan_ctrl #(.MSB_FIRST(0), .CNT_W(8)) dutA (
    .clk(clk), .rst_n(rstN[0]), .in_valid(inValid[0]), .in_data(inData[0]),
    .in_ready(inReady[0]), .mux_e(muxE[0]), .mux_s(muxS[0]), .mux_y(muxYA),
    .out_valid(outValid[0]), .out_bit(outBit[0]), .out_last(outLast[0]),
    .out_ready(outReady[0]), .busy(busy[0]), .word_cnt(wordCntA)
  );

  mux8_scan_ctrl #(.MSB_FIRST(1), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rstN[1]), .in_valid(inValid[1]), .in_data(inData[1]),
    .in_ready(inReady[1]), .mux_e(muxE[1]), .mux_s(muxS[1]), .mux_y(muxYB),
    .out_valid(outValid[1]), .out_bit(outBit[1]), .out_last(outLast[1]),
    .out_ready(outReady[1]), .busy(busy[1]), .word_cnt(wordCntB)
  );

  // The external 8:1 mux that each controller sequences.
  assign muxYA = muxE[0][muxS[0]];
  assign muxYB = muxE[1][muxS[1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] wordCnt(input int d);
    return (d == 0) ? wordCntA : {6'd0, wordCntB};
  endfunction

  task automatic applyStimulus(input int d, input logic valid, input logic [7:0] data,
                               input logic ready);
    inValid[d]  = valid;
    inData[d]   = data;
    outReady[d] = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One word through instance d; beat k must show select sel(k) and bit expBits[k].
  // With stall set, odd beats see two cycles of out_ready low first.
  task automatic sendWord(input int d, input logic [7:0] data, input logic [7:0] expBits,
                          input bit stall, input bit skipLoad, input bit chain,
                          input logic [7:0] nextData, input int expCnt, input string tag);
    logic [2:0] sel;
    int nStall;
    if (!skipLoad) begin
      @(negedge clk);
      applyStimulus(d, 1'b1, data, 1'b0);
      #1;
      checkOutput({tag, " idle in_ready"}, 32'(inReady[d]), 32'd1);
      checkOutput({tag, " idle out_valid"}, 32'(outValid[d]), 32'd0);
      @(posedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      sel    = (d == 0) ? 3'(k) : 3'(7 - k);
      nStall = (stall && (k % 2 == 1)) ? 2 : 0;
      for (int s = 0; s < nStall; s++) begin
        @(negedge clk);
        applyStimulus(d, 1'b1, 8'hE7, 1'b0);
        #1;
        checkOutput({tag, " stall out_valid"}, 32'(outValid[d]), 32'd1);
        checkOutput({tag, " stall mux_s"}, 32'(muxS[d]), 32'(sel));
        checkOutput({tag, " stall out_bit"}, 32'(outBit[d]), 32'(expBits[k]));
        checkOutput({tag, " stall in_ready"}, 32'(inReady[d]), 32'd0);
        @(posedge clk);
      end
      @(negedge clk);
      if (k == 7) applyStimulus(d, chain, nextData, 1'b1);
      else        applyStimulus(d, 1'b1, 8'hE7, 1'b1);
      #1;
      checkOutput({tag, " out_valid"}, 32'(outValid[d]), 32'd1);
      checkOutput({tag, " busy"}, 32'(busy[d]), 32'd1);
      checkOutput({tag, " mux_s"}, 32'(muxS[d]), 32'(sel));
      checkOutput({tag, " out_bit"}, 32'(outBit[d]), 32'(expBits[k]));
      checkOutput({tag, " out_last"}, 32'(outLast[d]), (k == 7) ? 32'd1 : 32'd0);
      checkOutput({tag, " in_ready"}, 32'(inReady[d]), (k == 7) ? 32'd1 : 32'd0);
      checkOutput({tag, " mux_e held"}, 32'(muxE[d]), 32'(data));
      @(posedge clk);
    end
    #1;
    checkOutput({tag, " word_cnt"}, 32'(wordCnt(d)), 32'(expCnt));
    if (!chain) begin
      @(negedge clk);
      applyStimulus(d, 1'b0, 8'h00, 1'b0);
      #1;
      checkOutput({tag, " back to idle out_valid"}, 32'(outValid[d]), 32'd0);
      checkOutput({tag, " back to idle busy"}, 32'(busy[d]), 32'd0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstN[d] = 1'b0;
      applyStimulus(d, 1'b0, 8'h00, 1'b0);
    end
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset A out_valid", 32'(outValid[0]), 32'd0);
    checkOutput("reset A busy", 32'(busy[0]), 32'd0);
    checkOutput("reset A out_last", 32'(outLast[0]), 32'd0);
    checkOutput("reset A mux_e", 32'(muxE[0]), 32'd0);
    checkOutput("reset A mux_s", 32'(muxS[0]), 32'd0);
    checkOutput("reset A word_cnt", 32'(wordCntA), 32'd0);
    checkOutput("reset B mux_s", 32'(muxS[1]), 32'd7);
    checkOutput("reset B word_cnt", 32'(wordCntB), 32'd0);
    @(negedge clk);
    rstN[0] = 1'b1;
    rstN[1] = 1'b1;
    #1;
    checkOutput("release A in_ready", 32'(inReady[0]), 32'd1);
    checkOutput("release B in_ready", 32'(inReady[1]), 32'd1);

    // LSB-first basic word, then a backpressured word, then two words back to back.
    sendWord(0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1, "A5");
    sendWord(0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 2, "3C stall");
    sendWord(0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 3, "FF b2b");
    sendWord(0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4, "00 b2b");

    // Reset three beats into a word abandons it and clears the counter.
    @(negedge clk);
    applyStimulus(0, 1'b1, 8'hC3, 1'b0);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      applyStimulus(0, 1'b0, 8'h00, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    rstN[0] = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(outValid[0]), 32'd0);
    checkOutput("midreset word_cnt", 32'(wordCntA), 32'd0);
    checkOutput("midreset mux_e", 32'(muxE[0]), 32'd0);
    checkOutput("midreset mux_s", 32'(muxS[0]), 32'd0);
    @(negedge clk);
    rstN[0] = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("post reset out_valid", 32'(outValid[0]), 32'd0);
    sendWord(0, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1, "5A after reset");

    // MSB-first with a 2-bit counter: five words, counts 1,2,3,0,1.
    sendWord(1, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 1, "B 01");
    sendWord(1, 8'h96, 8'h69, 1'b0, 1'b0, 1'b0, 8'h00, 2, "B 96");
    sendWord(1, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h0F, 3, "B F0");
    sendWord(1, 8'h0F, 8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 0, "B 0F wrap");
    sendWord(1, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1, "B A5");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/mux8_scan_ctrl.md
Name: mux8_scan_ctrl

Overview:
- Upstream sequencer for the 8:1 mux stage.
- Accepts 8-bit words over a valid/ready handshake and holds each word on the mux data inputs.
- Steps the 3-bit mux select through all eight positions, one per accepted beat.
- Returns the mux output as a handshaked serial bit stream with a last-bit marker and a completed-word counter.

Parameters:
- MSB_FIRST, 0: 0 = select order 0..7; 1 = select order 7..0.
- CNT_W, 8: width of the completed-word counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word valid
- in_data  input  8  upstream word
- in_ready  output  1  block can accept a word this cycle
- mux_e  output  8  held word, drives the mux data inputs
- mux_s  output  3  select, drives the mux select input
- mux_y  input  1  mux output, combinational return from the mux
- out_valid  output  1  serial bit valid
- out_bit  output  1  serial bit, equal to mux_y
- out_last  output  1  high on the eighth bit of a word
- out_ready  input  1  downstream accepts the bit
- busy  output  1  word in progress
- word_cnt  output  CNT_W  completed words, wraps

Behaviour:
- Interface (already decided): one clock (clk); asynchronous active-low reset (rst_n).
- Reset values, applied immediately on rst_n low:
  - state = IDLE
  - mux_e = 0
  - mux_s = 0 if MSB_FIRST=0, else 7
  - bit index = 0
  - word_cnt = 0
  - out_valid = 0, out_last = 0, busy = 0
  - in_ready = 1 after reset release
- States:
  - IDLE: in_ready=1, out_valid=0, busy=0.
  - SCAN: out_valid=1, busy=1.
- IDLE -> SCAN on in_valid && in_ready:
  - mux_e <= in_data.
  - Bit index <= 0; mux_s <= 0 (or 7 when MSB_FIRST=1).
- In SCAN:
  - out_bit = mux_y, combinational pass-through.
  - mux_s is registered; the first bit is presented the cycle after the load. Latency from load to first out_valid is 1 cycle.
  - A beat is accepted when out_valid && out_ready.
  - On each accepted beat: index increments; mux_s increments (or decrements when MSB_FIRST=1).
  - out_last = (index == 7).
- Backpressure: while out_ready=0, mux_s, mux_e and the index hold, and out_bit stays stable given a stable mux_y.
- Last beat accepted:
  - word_cnt increments, wrapping from 2^CNT_W-1 to 0.
  - If in_valid is also high, the new word loads in the same cycle. in_ready = 1 during an accepted last beat; state stays SCAN and index resets. This allows back-to-back words with no bubble.
  - Otherwise the block returns to IDLE.
- in_ready = (state==IDLE) || (state==SCAN && out_last && out_ready).
- mux_e changes only on a load. It is never modified mid-word.
- in_data is ignored whenever in_ready=0.
- Reset mid-word:
  - The word is abandoned and word_cnt is not incremented.
  - After reset, out_valid stays 0 until a new load.
- mux_s wraps internally only via reload; it never passes 7->0 within a word.

Test Plan:
- Reset, then in_data=8'hA5 with out_ready=1, MSB_FIRST=0 -> mux_s sequence 0..7; out_bit sequence 1,0,1,0,0,1,0,1; out_last on the 8th beat; word_cnt=1; returns to IDLE.
- MSB_FIRST=1, in_data=8'h01 -> mux_s 7..0; out_bit 0,0,0,0,0,0,0,1; out_last coincides with mux_s=0.
- Backpressure: out_ready toggles 1,0,0,1,... for in_data=8'h3C -> no beat lost or duplicated; mux_s holds while out_ready=0; exactly 8 accepted beats.
- Back-to-back: in_valid held high with 8'hFF then 8'h00 -> in_ready pulses on the last beat; 16 consecutive beats with no idle cycle; word_cnt=2.
- rst_n asserted after 3 beats of 8'hC3 -> immediate out_valid=0, word_cnt=0, mux_e=0; the next word starts at mux_s=0.
- CNT_W=2: run 5 words -> word_cnt sequence 1,2,3,0,1.
